// File: rtl/eth_rx_frame_buffer.sv
// eth_rx_frame_buffer: per-channel CRC-gated circular frame capture with a shared read port
module eth_rx_frame_buffer #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 7,
  parameter int CH_W   = 1
) (
  input  logic                clk_200,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   i_byte_tgl,
  input  logic [8*NUM_CH-1:0] i_byte_data,
  input  logic [NUM_CH-1:0]   i_frame_active,
  input  logic [NUM_CH-1:0]   i_crc_ok,
  input  logic [CH_W-1:0]     i_rd_ch,
  input  logic                i_rd_en,
  output logic [7:0]          o_rd_data,
  output logic                o_rd_last,
  output logic                o_rd_valid,
  output logic [NUM_CH-1:0]   o_frame_avail,
  output logic [NUM_CH-1:0]   o_ovf_flag,
  output logic [NUM_CH-1:0]   o_crc_err_flag,
  input  logic                i_clr_flags
);
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_END} state_t;
  localparam int DEPTH = 2**ADDR_W;
  logic [NUM_CH-1:0] w_pop;
  logic [8:0]        w_rword [NUM_CH];
  logic [8:0]        w_sel;
  // Merge the popped word; only the selected channel can pop in a cycle
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++) w_sel = w_sel | (w_pop[c] ? w_rword[c] : 9'd0);
  end
  // Read-port output register, one cycle after the pop request
  always_ff @(posedge clk_200 or negedge reset_n) begin
    if (!reset_n) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_last  <= 1'b0;
    end else begin
      o_rd_valid <= |w_pop;
      if (|w_pop) {o_rd_last, o_rd_data} <= w_sel;
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [8:0]        r_mem [DEPTH];
    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_fcnt;
    logic [ADDR_W-1:0] w_wr_ptr, w_cm_ptr, w_wr_inc;
    logic [7:0]        r_pend, w_pend;
    logic              r_pend_v, w_pend_v, r_drop, w_drop, r_tgl, r_ovf, r_cerr;
    logic              w_evt, w_full, w_we, w_commit, w_set_ovf, w_set_crc, w_pop_last;
    logic [8:0]        w_wdata;
    assign w_evt            = i_byte_tgl[g] ^ r_tgl;
    assign w_wr_inc         = r_wr_ptr + ADDR_W'(1);
    assign w_full           = w_wr_inc == r_rd_ptr;
    assign w_pop[g]         = i_rd_en && i_rd_ch == CH_W'(g) && r_fcnt != '0;
    assign w_rword[g]       = r_mem[r_rd_ptr];
    assign w_pop_last       = w_pop[g] & w_rword[g][8];
    assign o_frame_avail[g] = r_fcnt != '0;
    assign o_ovf_flag[g]    = r_ovf;
    assign o_crc_err_flag[g] = r_cerr;
    // Next state, buffer write, and commit/rollback at end of frame
    always_comb begin
      w_state   = r_state;
      w_wr_ptr  = r_wr_ptr;
      w_cm_ptr  = r_cm_ptr;
      w_pend    = r_pend;
      w_pend_v  = r_pend_v;
      w_drop    = r_drop;
      w_we      = 1'b0;
      w_wdata   = {1'b0, r_pend};
      w_commit  = 1'b0;
      w_set_ovf = 1'b0;
      w_set_crc = 1'b0;
      case (r_state)
        S_IDLE: if (i_frame_active[g]) begin
          w_state  = S_RECV;
          w_pend_v = 1'b0;
          w_drop   = 1'b0;
        end
        S_RECV: begin
          if (w_evt) begin
            w_we     = r_pend_v && !w_full;
            w_drop   = r_drop || (r_pend_v && w_full);
            w_pend   = i_byte_data[8*g +: 8];
            w_pend_v = 1'b1;
          end
          if (!i_frame_active[g]) w_state = S_END;
        end
        default: begin
          w_we      = r_pend_v && !w_full;
          w_wdata   = {1'b1, r_pend};
          w_drop    = r_drop || (r_pend_v && w_full);
          w_commit  = !w_drop && i_crc_ok[g] && r_pend_v;
          w_set_ovf = w_drop;
          w_set_crc = !w_drop && !i_crc_ok[g] && r_pend_v;
          w_state   = S_IDLE;
        end
      endcase
      if (w_we) w_wr_ptr = w_wr_inc;
      if (r_state == S_END) begin
        if (w_commit) w_cm_ptr = w_wr_ptr;
        else w_wr_ptr = r_cm_ptr;
      end
    end
    // Channel state, pointers, frame count and sticky flags
    always_ff @(posedge clk_200 or negedge reset_n) begin
      if (!reset_n) begin
        r_state  <= S_IDLE;
        r_wr_ptr <= '0;
        r_cm_ptr <= '0;
        r_rd_ptr <= '0;
        r_fcnt   <= '0;
        r_pend   <= '0;
        r_pend_v <= 1'b0;
        r_drop   <= 1'b0;
        r_tgl    <= 1'b0;
        r_ovf    <= 1'b0;
        r_cerr   <= 1'b0;
      end else begin
        r_state  <= w_state;
        r_wr_ptr <= w_wr_ptr;
        r_cm_ptr <= w_cm_ptr;
        r_rd_ptr <= r_rd_ptr + ADDR_W'(w_pop[g]);
        r_fcnt   <= r_fcnt + ADDR_W'(w_commit) - ADDR_W'(w_pop_last);
        r_pend   <= w_pend;
        r_pend_v <= w_pend_v;
        r_drop   <= w_drop;
        r_tgl    <= i_byte_tgl[g];
        r_ovf    <= w_set_ovf | (r_ovf & !i_clr_flags);
        r_cerr   <= w_set_crc | (r_cerr & !i_clr_flags);
      end
    end
    // Buffer storage write port; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_200) begin
      if (w_we) r_mem[r_wr_ptr] <= w_wdata;
    end
  end
endmodule

// File: doc/eth_rx_frame_buffer.md
Name: eth_rx_frame_buffer

Overview:
- Parametrised multi-channel receive capture buffer that replaces the per-port single-RAM byte logger in the Ethernet controller top.
- Each channel takes a toggle-per-byte stream from its RX_Ethernet-style receiver and holds it in a per-channel circular frame buffer.
- Frames are committed only when CRC is good; bad, empty or overflowing frames are rolled back.
- A shared, channel-selectable read port lets downstream logic drain whole frames, with an end-of-frame marker.

Parameters:
NUM_CH, 2, number of receive channels (1..8)
ADDR_W, 7, per-channel buffer address width; depth = 2**ADDR_W entries, usable capacity 2**ADDR_W-1 bytes
CH_W, 1, width of rd_ch; must satisfy 2**CH_W >= NUM_CH

Ports:
clk_200  in  1  system clock
reset_n  in  1  async active-low reset
byte_tgl  in  NUM_CH  per-channel byte strobe; each change of level = one new byte
byte_data  in  8*NUM_CH  per-channel byte; channel c at [8c+7:8c]; stable when its toggle changes
frame_active  in  NUM_CH  per-channel level, high for the duration of a frame
crc_ok  in  NUM_CH  per-channel CRC result; valid while frame_active is low after a frame
rd_ch  in  CH_W  channel selected for reading
rd_en  in  1  pop one byte from channel rd_ch
rd_data  out  8  popped byte
rd_last  out  1  popped byte is the last byte of its frame
rd_valid  out  1  rd_data/rd_last valid this cycle
frame_avail  out  NUM_CH  channel holds at least one committed frame
ovf_flag  out  NUM_CH  sticky: a frame was dropped for lack of space
crc_err_flag  out  NUM_CH  sticky: a frame was dropped for bad CRC
clr_flags  in  1  clears all sticky flags

Behaviour:
- Reset: reset is reset_n, asynchronous, active-low; the clock is clk_200. All outputs reset to 0. All pointers, frame counts, FSMs and pending registers are cleared, and each channel's byte_tgl history register loads 0. A reset mid-frame discards all buffered and partial data.
- All inputs are synchronous to clk_200. A byte event is byte_tgl[c] != tgl_q[c], where tgl_q is a registered copy.
- Per-channel storage: a (2**ADDR_W) x 9 memory holding {last, data[7:0]}. Pointers:
  - wr_ptr: next write address
  - cm_ptr: end of the last committed frame
  - rd_ptr: next read address
  - All pointers are ADDR_W bits and wrap modulo depth.
- Full condition: wr_ptr+1 == rd_ptr.
- Per-channel FSM, states IDLE, RECV, END:
  - IDLE: byte events are ignored. When frame_active[c] is high, go to RECV and clear pend_v and drop.
  - RECV, on a byte event:
    - If pend_v is set and the buffer is not full, write {0, pend} at wr_ptr and increment wr_ptr.
    - If pend_v is set and the buffer is full, set drop.
    - In all cases load pend from byte_data and set pend_v.
  - RECV, frame_active low: go to END. A byte event in the same cycle is still accepted as part of the frame.
  - END (exactly one cycle):
    - If pend_v is set and the buffer is not full, write {1, pend}.
    - If pend_v is set and the buffer is full, set drop.
    - Sample crc_ok[c].
    - Commit when !drop && crc_ok && pend_v: cm_ptr takes the post-write wr_ptr and fcnt is incremented.
    - Otherwise roll back: wr_ptr takes cm_ptr.
    - Set ovf_flag if drop; else set crc_err_flag if !crc_ok and pend_v.
    - An empty frame is silently discarded.
    - Go to IDLE.
- The readable region is rd_ptr..cm_ptr. Uncommitted bytes are never readable.
- fcnt is ADDR_W bits. frame_avail[c] = (fcnt != 0).
- Read path:
  - rd_en with frame_avail[rd_ch] = 1: read at rd_ptr, increment rd_ptr, and one cycle later drive rd_valid=1 with rd_data and rd_last.
  - Popping a byte with last=1 decrements fcnt.
  - rd_en on a channel with no committed frame, or rd_ch >= NUM_CH: ignored, rd_valid=0.
- Simultaneous events:
  - Commit and last-byte pop in the same cycle leave fcnt unchanged.
  - A read freeing space in the same cycle as a write does not relieve the full check; full is evaluated on registered pointers.
- Flags: clr_flags clears the sticky flags. A set event in the same cycle as clr_flags wins.
- Back-to-back frames: frame_active may rise again in the cycle after END; IDLE samples it on that cycle.
- Size: expected 150-300 lines of RTL with a generate loop over channels.

Test Plan:
- Ch0, 4 bytes 0x11,0x22,0x33,0x44, crc_ok=1 → frame_avail[0]=1. Four rd_en pops return 0x11..0x44, rd_last=1 only on 0x44, 1-cycle latency. frame_avail[0] returns to 0.
- Ch1, 5 bytes, crc_ok=0 → nothing readable, crc_err_flag[1]=1, wr_ptr back to cm_ptr. A following good 2-byte frame reads back correctly.
- ADDR_W=4 (15 usable bytes): 20-byte good frame → dropped, ovf_flag=1, buffer empty. A following 15-byte good frame is fully stored and read back.
- Both channels receive interleaved good frames simultaneously; pop on ch0 while ch1 commits → data is per-channel correct and fcnt is correct, including a commit coinciding with a last-byte pop.
- Byte toggle in the same cycle as the frame_active fall → that byte is stored as the last byte with rd_last=1. Toggles while IDLE are ignored.
- reset_n asserted mid-frame with 3 frames buffered → all outputs 0 and buffer empty. A new frame after release is captured normally.
